// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, pipeline control
// from ID/EX, and the IF/ID register outputs.
`default_nettype none

interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_inst,
    input  imem_rdata, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_inst,
    output imem_rdata, stall_i, redirect_i, redirect_pc_i
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC owner, 1-cycle-latency imem requester, skid FIFO
// that absorbs decode stalls, IF/ID register, and EX redirect/squash handling.
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          SKID_DEPTH = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  if_fetch_stage_if.master bus
);

  localparam int          PW       = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int          CW       = PW + 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]   pc;
  logic [31:0]   pc_f2;
  logic          inflight;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   skid_pc   [SKID_DEPTH];
  logic [31:0]   skid_inst [SKID_DEPTH];

  logic req;
  logic skid_empty;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc_i[1:0];
  assign skid_empty = (count == '0);

  // Credit check: a request is only issued when its response is guaranteed a
  // landing slot (IF/ID or skid), counting the word already in flight.
  always_comb begin
    req = rst_n && !bus.redirect_i &&
          ((32'(count) + 32'(inflight) + 32'(bus.stall_i)) < 32'(SKID_DEPTH + 1));
  end

  // A returning word bypasses the skid only when decode is free and nothing is queued ahead of it.
  assign push = !bus.redirect_i && inflight && (bus.stall_i || !skid_empty);
  assign pop  = !bus.redirect_i && !bus.stall_i && !skid_empty;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= RESET_PC;
      pc_f2           <= '0;
      inflight        <= 1'b0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      bus.if_id_valid <= 1'b0;
      bus.if_id_pc    <= '0;
      bus.if_id_pc4   <= '0;
      bus.if_id_inst  <= NOP;
    end else if (bus.redirect_i) begin
      pc              <= {bus.redirect_pc_i[31:2], 2'b00};
      inflight        <= 1'b0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      bus.if_id_valid <= 1'b0;
    end else begin
      if (req) begin
        pc    <= pc + 32'd4;
        pc_f2 <= pc;
      end
      inflight <= req;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;

      if (!bus.stall_i) begin
        if (!skid_empty) begin
          bus.if_id_valid <= 1'b1;
          bus.if_id_pc    <= skid_pc[rd_ptr];
          bus.if_id_pc4   <= skid_pc[rd_ptr] + 32'd4;
          bus.if_id_inst  <= skid_inst[rd_ptr];
        end else if (inflight) begin
          bus.if_id_valid <= 1'b1;
          bus.if_id_pc    <= pc_f2;
          bus.if_id_pc4   <= pc_f2 + 32'd4;
          bus.if_id_inst  <= bus.imem_rdata;
        end else begin
          bus.if_id_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      skid_pc[wr_ptr]   <= pc_f2;
      skid_inst[wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/redirect traffic,
// checked every cycle against a queue-based reference model of the fetch rules.
`default_nettype none

module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(RESET_PC), .SKID_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int total  = 0;
  int passed = 0;

  // Reference model: PC, one outstanding fetch, and an unbounded queue of
  // fetched-but-not-yet-decoded words that the credit rule keeps small.
  logic [31:0] m_pc;
  logic [31:0] m_tag;
  bit          m_inflight;
  logic [63:0] m_q[$];
  bit          m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_inst;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_ifid();
    check("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    if (m_valid) begin
      check("if_id_pc",   bus.if_id_pc,   m_ifpc);
      check("if_id_pc4",  bus.if_id_pc4,  m_ifpc + 32'd4);
      check("if_id_inst", bus.if_id_inst, m_inst);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the request,
  // advance the model at the rising edge, return memory data, check IF/ID.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit          req;
    logic [31:0] a;
    logic [63:0] w;
    bus.stall_i       = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    #1;
    req = !rd && ((m_q.size() + int'(m_inflight) + int'(st)) < DEPTH + 1);
    check("imem_req", 32'(bus.imem_req), 32'(req));
    if (req) check("imem_addr", bus.imem_addr, m_pc);
    a = bus.imem_addr;
    @(posedge clk);
    if (rd) begin
      m_pc       = {rpc[31:2], 2'b00};
      m_inflight = 1'b0;
      m_q.delete();
      m_valid    = 1'b0;
    end else begin
      if (m_inflight) m_q.push_back({m_tag, memword(m_tag)});
      if (!st) begin
        if (m_q.size() > 0) begin
          w       = m_q.pop_front();
          m_ifpc  = w[63:32];
          m_inst  = w[31:0];
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (req) begin
        m_tag = m_pc;
        m_pc  = m_pc + 32'd4;
      end
      m_inflight = req;
    end
    #1 bus.imem_rdata = memword(a);
    @(negedge clk);
    check_ifid();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    m_pc       = RESET_PC;
    m_inflight = 1'b0;
    m_q.delete();
    m_valid    = 1'b0;
    check("rst_valid", 32'(bus.if_id_valid), 32'h0);
    check("rst_pc",    bus.if_id_pc,         32'h0);
    check("rst_pc4",   bus.if_id_pc4,        32'h0);
    check("rst_inst",  bus.if_id_inst,       32'h0000_0013);
    check("rst_req",   32'(bus.imem_req),    32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_hold", 32'(bus.imem_req), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_rdata    = 32'h0;
    @(negedge clk);
    do_reset();

    // Straight-line fetch from reset
    repeat (6) step(1'b0, 1'b0, 32'h0);
    // Three-cycle decode stall, then drain in order
    repeat (3) step(1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    // Redirect to 0x100
    step(1'b0, 1'b1, 32'h0000_0100);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    // Redirect while stalled with a full skid
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0300);
    repeat (2) step(1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    // Misaligned redirect target
    step(1'b0, 1'b1, 32'h0000_0203);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    // Back-to-back redirects: last one wins
    step(1'b0, 1'b1, 32'h0000_0400);
    step(1'b0, 1'b1, 32'h0000_0500);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    // Reset in the middle of a stall with a full skid
    repeat (4) step(1'b1, 1'b0, 32'h0);
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0);
    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (5) step(1'b0, 1'b0, 32'h0);

    // Random stall/redirect traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), $urandom);
      if (i == 200) begin
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
